// File: rtl/word_serializer_pkg.sv
// Shared constants and helpers for the word serializer and its byte shifter.
package word_serializer_pkg;

   localparam int BYTE_W = 8;

   // Number of whole bytes in an n-bit word.
   function automatic int num_bytes(input int n);
      return n / BYTE_W;
   endfunction

endpackage

// File: rtl/word_serializer_byte_shift_reg.sv
// Word-wide shift register that exposes the byte at its send end and
// advances by one byte per shift toward that end.
module byte_shift_reg
   import word_serializer_pkg::*;
#(
   parameter int N         = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_load,
   input  logic [N-1:0]      i_word,
   input  logic              i_shift,
   output logic [BYTE_W-1:0] o_byte
);

   logic [N-1:0] r_shreg;

   // Datapath register: load wins over shift; no reset, contents are don't-care when idle.
   always_ff @(posedge i_clk) begin
      if (i_load) begin
         r_shreg <= i_word;
      end else if (i_shift) begin
         if (MSB_FIRST) begin
            r_shreg <= r_shreg << BYTE_W;
         end else begin
            r_shreg <= r_shreg >> BYTE_W;
         end
      end
   end

   generate
      if (MSB_FIRST) begin : g_msb
         assign o_byte = r_shreg[N-1 -: BYTE_W];
      end else begin : g_lsb
         assign o_byte = r_shreg[BYTE_W-1:0];
      end
   endgenerate

endmodule

// File: rtl/word_serializer.sv
// Splits an N-bit word into N/8 bytes for a UART transmitter, one strobe per
// byte, with a one-word holding buffer so a following word can be taken early.
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int N         = 16,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CW        = $clog2(N/8 + 1)
) (
   input  logic              iCE_CLK,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [N-1:0]      rx_bytes,
   output logic              rx_ready,
   input  logic              is_transmitting,
   output logic [BYTE_W-1:0] tx_byte,
   output logic              tx_valid,
   output logic              busy
);

   localparam int           NB    = num_bytes(N);
   localparam logic [CW-1:0] NB_CW = CW'(NB);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_SEND       = 2'd1;
   localparam logic [1:0] ST_WAIT_START = 2'd2;
   localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE       = ST_IDLE,
      SEND       = ST_SEND,
      WAIT_START = ST_WAIT_START,
      WAIT_DONE  = ST_WAIT_DONE
   } state_t;

   state_t              r_state;
   logic [CW-1:0]       r_left;
   logic [N-1:0]        r_pend;
   logic                r_pend_v;
   logic                r_tx_valid;
   logic [BYTE_W-1:0]   r_tx_byte;

   logic                w_accept;
   logic                w_load;
   logic                w_shift;
   logic [N-1:0]        w_load_word;
   logic [BYTE_W-1:0]   w_cur_byte;

   assign w_accept    = rx_valid && !r_pend_v;
   // The shifter is loaded from the holding buffer whenever it is occupied,
   // otherwise straight from the input (only possible in IDLE).
   assign w_load_word = r_pend_v ? r_pend : rx_bytes;
   assign w_load      = ((r_state == IDLE) && (r_pend_v || w_accept)) ||
                        ((r_state == WAIT_DONE) && !is_transmitting &&
                         (r_left == '0) && r_pend_v);
   assign w_shift     = (r_state == SEND) && !is_transmitting;

   byte_shift_reg #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .i_clk   (iCE_CLK),
      .i_load  (w_load),
      .i_word  (w_load_word),
      .i_shift (w_shift),
      .o_byte  (w_cur_byte)
   );

   // Holding buffer data: captures a word offered while a word is in flight.
   always_ff @(posedge iCE_CLK) begin
      if (w_accept && (r_state != IDLE)) begin
         r_pend <= rx_bytes;
      end
   end

   // Control FSM with registered strobe/byte outputs.
   always_ff @(posedge iCE_CLK) begin
      if (rst) begin
         r_state    <= IDLE;
         r_left     <= '0;
         r_pend_v   <= 1'b0;
         r_tx_valid <= 1'b0;
         r_tx_byte  <= '0;
      end else begin
         r_tx_valid <= 1'b0;
         if (w_accept && (r_state != IDLE)) begin
            r_pend_v <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               // A buffered word left over from a finishing word is served first.
               if (r_pend_v) begin
                  r_pend_v <= 1'b0;
                  r_left   <= NB_CW;
                  r_state  <= SEND;
               end else if (w_accept) begin
                  r_left  <= NB_CW;
                  r_state <= SEND;
               end
            end
            SEND: begin
               if (!is_transmitting) begin
                  r_tx_valid <= 1'b1;
                  r_tx_byte  <= w_cur_byte;
                  r_left     <= r_left - CW'(1);
                  r_state    <= WAIT_START;
               end
            end
            WAIT_START: begin
               if (is_transmitting) begin
                  r_state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!is_transmitting) begin
                  if (r_left != '0) begin
                     r_state <= SEND;
                  end else if (r_pend_v) begin
                     r_pend_v <= 1'b0;
                     r_left   <= NB_CW;
                     r_state  <= SEND;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rx_ready = !r_pend_v;
   assign busy     = (r_state != IDLE) || r_pend_v;
   assign tx_valid = r_tx_valid;
   assign tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench: three serializer instances (32-bit MSB-first, 32-bit
// LSB-first, 8-bit), each driving its own simple UART busy model.
module tb_word_serializer;

   typedef struct {
      int         inst;
      logic [7:0] b;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rxv       [3];
   logic [31:0] rxb       [2];
   logic [7:0]  rxb8;
   logic        rdy       [3];
   logic        is_tx     [3];
   logic        force_bsy [3];
   logic [7:0]  txb       [3];
   logic        txv       [3];
   logic        bsy       [3];

   exp_t exp_q[$];
   int   strobes [3];
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   word_serializer #(.N(32), .MSB_FIRST(1'b1)) u_msb (
      .iCE_CLK(clk), .rst(rst), .rx_valid(rxv[0]), .rx_bytes(rxb[0]),
      .rx_ready(rdy[0]), .is_transmitting(is_tx[0]), .tx_byte(txb[0]),
      .tx_valid(txv[0]), .busy(bsy[0]));

   word_serializer #(.N(32), .MSB_FIRST(1'b0)) u_lsb (
      .iCE_CLK(clk), .rst(rst), .rx_valid(rxv[1]), .rx_bytes(rxb[1]),
      .rx_ready(rdy[1]), .is_transmitting(is_tx[1]), .tx_byte(txb[1]),
      .tx_valid(txv[1]), .busy(bsy[1]));

   word_serializer #(.N(8), .MSB_FIRST(1'b1)) u_n8 (
      .iCE_CLK(clk), .rst(rst), .rx_valid(rxv[2]), .rx_bytes(rxb8),
      .rx_ready(rdy[2]), .is_transmitting(is_tx[2]), .tx_byte(txb[2]),
      .tx_valid(txv[2]), .busy(bsy[2]));

   // UART model: busy for 10 cycles starting the edge after each strobe.
   generate
      for (genvar g = 0; g < 3; g++) begin : g_uart
         int   cnt = 0;
         logic u   = 1'b0;
         always @(posedge clk) begin
            if (txv[g]) begin
               u   <= 1'b1;
               cnt <= 10;
            end else if (cnt > 1) begin
               cnt <= cnt - 1;
            end else begin
               cnt <= 0;
               u   <= 1'b0;
            end
         end
         assign is_tx[g] = u | force_bsy[g];
      end
   endgenerate

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
   endtask

   task automatic push4(input int inst, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
      exp_q.push_back('{inst, b0});
      exp_q.push_back('{inst, b1});
      exp_q.push_back('{inst, b2});
      exp_q.push_back('{inst, b3});
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (txv[i]) begin
               strobes[i]++;
               if (exp_q.size() == 0) begin
                  n_chk++;
                  $display("FAIL strobe_unexpected: inst %0d byte %0h, expected no strobe", i, txb[i]);
               end else begin
                  e = exp_q.pop_front();
                  chk("strobe_inst", i, e.inst);
                  chk("strobe_byte", {24'd0, txb[i]}, {24'd0, e.b});
               end
            end
         end
      end
   endtask

   // Offers a word and returns once it has been accepted; waited counts stalled cycles.
   task automatic send_word(input int inst, input logic [31:0] w, output int waited);
      @(negedge clk);
      rxv[inst] = 1'b1;
      if (inst == 2) rxb8 = w[7:0];
      else rxb[inst] = w;
      waited = 0;
      while (!rdy[inst] && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (!rdy[inst]) begin
         n_chk++;
         $display("FAIL accept_timeout: inst %0d rx_ready 0, expected 1", inst);
      end
      @(posedge clk);
      #1 rxv[inst] = 1'b0;
   endtask

   task automatic wait_done(input int inst);
      int k = 0;
      while ((bsy[inst] || exp_q.size() != 0 || is_tx[inst]) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("idle_busy", {31'd0, bsy[inst]}, 32'd0);
      chk("idle_queue", exp_q.size(), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      int base;
      int k;
      rst = 1'b1;
      rxb8 = '0;
      for (int i = 0; i < 3; i++) begin
         rxv[i] = 1'b0;
         force_bsy[i] = 1'b0;
         strobes[i] = 0;
      end
      rxb[0] = '0;
      rxb[1] = '0;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_rx_ready", {31'd0, rdy[i]}, 32'd1);
         chk("rst_busy", {31'd0, bsy[i]}, 32'd0);
         chk("rst_tx_valid", {31'd0, txv[i]}, 32'd0);
         chk("rst_tx_byte", {24'd0, txb[i]}, 32'd0);
      end
      rst = 1'b0;

      // MSB-first word
      push4(0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
      send_word(0, 32'hA1B2C3D4, w);
      wait_done(0);

      // LSB-first word
      push4(1, 8'hD4, 8'hC3, 8'hB2, 8'hA1);
      send_word(1, 32'hA1B2C3D4, w);
      wait_done(1);

      // Back-to-back words plus a third that must stall on the holding buffer
      base = strobes[0];
      push4(0, 8'h11, 8'h22, 8'h33, 8'h44);
      send_word(0, 32'h11223344, w);
      push4(0, 8'h55, 8'h66, 8'h77, 8'h88);
      send_word(0, 32'h55667788, w);
      chk("second_no_stall", w, 32'd0);
      push4(0, 8'h99, 8'hAA, 8'hBB, 8'hCC);
      send_word(0, 32'h99AABBCC, w);
      chk("third_stalled", {31'd0, (w >= 30)}, 32'd1);
      chk("third_accept_after_4", strobes[0] - base, 32'd4);
      wait_done(0);
      chk("b2b_strobe_count", strobes[0] - base, 32'd12);

      // UART busy at accept time
      force_bsy[0] = 1'b1;
      base = strobes[0];
      push4(0, 8'hCA, 8'hFE, 8'hF0, 8'h0D);
      send_word(0, 32'hCAFEF00D, w);
      repeat (20) @(negedge clk);
      chk("no_strobe_while_busy", strobes[0] - base, 32'd0);
      force_bsy[0] = 1'b0;
      @(negedge clk);
      chk("strobe_after_fall", {31'd0, txv[0]}, 32'd1);
      wait_done(0);

      // Reset after the second byte
      base = strobes[0];
      push4(0, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
      send_word(0, 32'hDEADBEEF, w);
      k = 0;
      while ((strobes[0] - base) < 2 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("two_bytes_before_rst", strobes[0] - base, 32'd2);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_tx_valid", {31'd0, txv[0]}, 32'd0);
      chk("mid_rst_tx_byte", {24'd0, txb[0]}, 32'd0);
      chk("mid_rst_rx_ready", {31'd0, rdy[0]}, 32'd1);
      chk("mid_rst_busy", {31'd0, bsy[0]}, 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("no_strobe_after_rst", strobes[0] - base, 32'd2);
      push4(0, 8'h01, 8'h02, 8'h03, 8'h04);
      send_word(0, 32'h01020304, w);
      wait_done(0);
      chk("post_rst_strobes", strobes[0] - base, 32'd6);

      // Single-byte word width
      exp_q.push_back('{2, 8'h5A});
      send_word(2, 32'h0000005A, w);
      wait_done(2);
      chk("n8_strobe_count", strobes[2], 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
